// File: rtl/pll_seq_pkg.sv
// Shared state codes, default timing and counter sizing for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        StPwd       = 3'd0,
        StRst       = 3'd1,
        StWaitLock  = 3'd2,
        StStableChk = 3'd3,
        StRun       = 3'd4,
        StFail      = 3'd5
    } state_e;

    localparam int unsigned DefPwdCycles        = 3;
    localparam int unsigned DefRstCycles        = 3;
    localparam int unsigned DefLockTimeoutCycles = 50000;
    localparam int unsigned DefLockStableCycles = 64;
    localparam int unsigned DefMaxRetries       = 3;
    localparam int unsigned DefSyncStages       = 3;

    // Bits needed to hold values 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer bringing the asynchronous PLL lock into the clkin1 domain.
module pll_lock_sync #(
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic clkin1,
    input  logic rst,
    input  logic pll_lock,
    output logic lock_s
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clkin1 or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/reset sequencer: drives pwd/rst pins, qualifies lock, gates the user reset,
// retries on lock timeout and restarts on lock loss.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PWD_CYCLES          = DefPwdCycles,
    parameter int unsigned RST_CYCLES          = DefRstCycles,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DefLockTimeoutCycles,
    parameter int unsigned LOCK_STABLE_CYCLES  = DefLockStableCycles,
    parameter int unsigned MAX_RETRIES         = DefMaxRetries,
    parameter int unsigned SYNC_STAGES         = DefSyncStages
) (
    input  logic                                clkin1,
    input  logic                                rst,
    input  logic                                pll_lock,
    input  logic                                restart_req,
    output logic                                pll_pwd,
    output logic                                pll_rst,
    output logic                                user_rst,
    output logic                                clk_ready,
    output logic                                lock_lost,
    output logic                                fail,
    output logic [cnt_width(MAX_RETRIES)-1:0]   retry_cnt,
    output logic [7:0]                          lock_loss_cnt,
    output logic [2:0]                          state
);

    localparam int unsigned PhaseW = cnt_width((PWD_CYCLES > RST_CYCLES) ? PWD_CYCLES : RST_CYCLES);
    localparam int unsigned TmoW   = cnt_width(LOCK_TIMEOUT_CYCLES);
    localparam int unsigned StabW  = cnt_width(LOCK_STABLE_CYCLES);
    localparam int unsigned RetryW = cnt_width(MAX_RETRIES);

    localparam logic [PhaseW-1:0] PwdLast  = PhaseW'(PWD_CYCLES - 1);
    localparam logic [PhaseW-1:0] RstLast  = PhaseW'(RST_CYCLES - 1);
    localparam logic [TmoW-1:0]   TmoLast  = TmoW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [StabW-1:0]  StabLast = StabW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);

    logic lock_s;

    state_e              state_q, state_d;
    logic [PhaseW-1:0]   phase_q, phase_d;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic [StabW-1:0]    stab_q, stab_d;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic [7:0]          loss_q, loss_d;
    logic                lost_d;
    logic                tmo_hit;

    logic pwd_q, prst_q, urst_q, ready_q, lost_q, fail_q;

    pll_lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clkin1   (clkin1),
        .rst      (rst),
        .pll_lock (pll_lock),
        .lock_s   (lock_s)
    );

    assign tmo_hit = (tmo_q == TmoLast);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        tmo_d   = tmo_q;
        stab_d  = stab_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        lost_d  = 1'b0;

        if (restart_req) begin
            state_d = StPwd;
            retry_d = '0;
            tmo_d   = '0;
            stab_d  = '0;
        end else begin
            case (state_q)
                StPwd: begin
                    if (phase_q == PwdLast) state_d = StRst;
                    else                    phase_d = phase_q + PhaseW'(1);
                end
                StRst: begin
                    if (phase_q == RstLast) begin
                        state_d = StWaitLock;
                        tmo_d   = '0;
                    end else begin
                        phase_d = phase_q + PhaseW'(1);
                    end
                end
                StWaitLock: begin
                    tmo_d = tmo_q + TmoW'(1);
                    if (lock_s) begin
                        state_d = StStableChk;
                    end else if (tmo_hit) begin
                        if (retry_q == RetryMax) begin
                            state_d = StFail;
                        end else begin
                            state_d = StPwd;
                            retry_d = retry_q + RetryW'(1);
                        end
                    end
                end
                StStableChk: begin
                    tmo_d = tmo_q + TmoW'(1);
                    // Timeout wins even on the cycle the stable count would complete.
                    if (tmo_hit) begin
                        if (retry_q == RetryMax) begin
                            state_d = StFail;
                        end else begin
                            state_d = StPwd;
                            retry_d = retry_q + RetryW'(1);
                        end
                    end else if (!lock_s) begin
                        state_d = StWaitLock;
                    end else if (stab_q == StabLast) begin
                        state_d = StRun;
                    end else begin
                        stab_d = stab_q + StabW'(1);
                    end
                end
                StRun: begin
                    if (!lock_s) begin
                        state_d = StPwd;
                        lost_d  = 1'b1;
                        retry_d = '0;
                        if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                    end
                end
                StFail: state_d = StFail;
                default: state_d = StPwd;
            endcase
        end

        if (restart_req || (state_d != state_q)) phase_d = '0;
        if (state_d == StStableChk && state_q != StStableChk) stab_d = '0;
    end

    always_ff @(posedge clkin1 or posedge rst) begin
        if (rst) begin
            state_q <= StPwd;
            phase_q <= '0;
            tmo_q   <= '0;
            stab_q  <= '0;
            retry_q <= '0;
            loss_q  <= '0;
            pwd_q   <= 1'b1;
            prst_q  <= 1'b1;
            urst_q  <= 1'b1;
            ready_q <= 1'b0;
            lost_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            tmo_q   <= tmo_d;
            stab_q  <= stab_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
            // Outputs decode the next state so they switch on the same edge as state.
            pwd_q   <= (state_d == StPwd) || (state_d == StFail);
            prst_q  <= (state_d == StPwd) || (state_d == StRst) || (state_d == StFail);
            urst_q  <= (state_d != StRun);
            ready_q <= (state_d == StRun);
            lost_q  <= lost_d;
            fail_q  <= (state_d == StFail);
        end
    end

    assign pll_pwd       = pwd_q;
    assign pll_rst       = prst_q;
    assign user_rst      = urst_q;
    assign clk_ready     = ready_q;
    assign lock_lost     = lost_q;
    assign fail          = fail_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: each expected state transition (state, dwell, counters) is queued ahead
// of the stimulus; a negedge monitor pops and checks one entry per observed transition.
module tb_pll_lock_sequencer;

    logic       clkin1 = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       restart_req = 1'b0;
    logic       pll_pwd, pll_rst, user_rst, clk_ready, lock_lost, fail;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [2:0] st;
        int         dwell;
        logic [1:0] rcnt;
        logic [7:0] lcnt;
        logic       lost;
    } exp_t;

    exp_t exp_q[$];

    pll_lock_sequencer #(
        .LOCK_TIMEOUT_CYCLES (200)
    ) dut (
        .clkin1        (clkin1),
        .rst           (rst),
        .pll_lock      (pll_lock),
        .restart_req   (restart_req),
        .pll_pwd       (pll_pwd),
        .pll_rst       (pll_rst),
        .user_rst      (user_rst),
        .clk_ready     (clk_ready),
        .lock_lost     (lock_lost),
        .fail          (fail),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt),
        .state         (state)
    );

    always #10 clkin1 = ~clkin1;

    initial forever begin
        @(posedge clkin1);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic [2:0] st, input int dwell, input logic [1:0] rcnt,
                        input logic [7:0] lcnt, input logic lost);
        exp_t e;
        e.st = st; e.dwell = dwell; e.rcnt = rcnt; e.lcnt = lcnt; e.lost = lost;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_vals();
        chk("rst_state", state, 0);
        chk("rst_pll_pwd", pll_pwd, 1);
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_user_rst", user_rst, 1);
        chk("rst_clk_ready", clk_ready, 0);
        chk("rst_lock_lost", lock_lost, 0);
        chk("rst_fail", fail, 0);
        chk("rst_retry_cnt", retry_cnt, 0);
        chk("rst_lock_loss_cnt", lock_loss_cnt, 0);
    endtask

    task automatic wait_state(input logic [2:0] st);
        int n = 0;
        while (state !== st) begin
            @(negedge clkin1);
            n++;
            if (n > 2000) begin
                total++;
                bad++;
                $display("FAIL wait_state: state %0d never reached %0d", state, st);
                return;
            end
        end
    endtask

    // Called at the negedge just after RUN entry: restart 6 edges in, dropping lock too.
    task automatic restart_drop();
        repeat (5) @(negedge clkin1);
        restart_req = 1'b1;
        pll_lock    = 1'b0;
        @(negedge clkin1);
        restart_req = 1'b0;
    endtask

    // Monitor: one scoreboard entry per state change.
    initial begin : monitor
        exp_t       e;
        logic [2:0] prev_st = 3'd0;
        int         last_edge = 0;
        forever begin
            @(negedge clkin1);
            if (rst) begin
                prev_st   = state;
                last_edge = cyc;
            end else if (state !== prev_st) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_transition: got state %0d expected none", state);
                end else begin
                    e = exp_q.pop_front();
                    chk("state", state, e.st);
                    chk("dwell", cyc - last_edge, e.dwell);
                    chk("pll_pwd", pll_pwd, (e.st == 0 || e.st == 5));
                    chk("pll_rst", pll_rst, (e.st <= 1 || e.st == 5));
                    chk("user_rst", user_rst, (e.st != 4));
                    chk("clk_ready", clk_ready, (e.st == 4));
                    chk("fail", fail, (e.st == 5));
                    chk("lock_lost", lock_lost, e.lost);
                    chk("retry_cnt", retry_cnt, e.rcnt);
                    chk("lock_loss_cnt", lock_loss_cnt, e.lcnt);
                end
                prev_st   = state;
                last_edge = cyc;
            end else if (lock_lost) begin
                total++;
                bad++;
                $display("FAIL lock_lost_stray: got 1 expected 0 (cycle %0d)", cyc);
            end
        end
    end

    initial begin : watchdog
        #500000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : stim
        #50;
        check_reset_vals();

        // Nominal lock, 40 cycles into WAIT_LOCK.
        push(1, 3, 0, 0, 0);
        push(2, 3, 0, 0, 0);
        push(3, 44, 0, 0, 0);
        push(4, 64, 0, 0, 0);
        #55 rst = 1'b0;
        wait_state(2);
        repeat (40) @(negedge clkin1);
        pll_lock = 1'b1;
        wait_state(4);

        // Lock loss in RUN for 10 cycles, then relock.
        push(0, 14, 0, 1, 1);
        push(1, 3, 0, 1, 0);
        push(2, 3, 0, 1, 0);
        push(3, 4, 0, 1, 0);
        push(4, 64, 0, 1, 0);
        repeat (10) @(negedge clkin1);
        pll_lock = 1'b0;
        repeat (10) @(negedge clkin1);
        pll_lock = 1'b1;
        wait_state(4);

        // Restart in RUN (no lock_lost), then flapping lock: 30 high, 2 low, high.
        push(0, 6, 0, 1, 0);
        push(1, 3, 0, 1, 0);
        push(2, 3, 0, 1, 0);
        push(3, 4, 0, 1, 0);
        push(2, 30, 0, 1, 0);
        push(3, 2, 0, 1, 0);
        push(4, 64, 0, 1, 0);
        restart_drop();
        wait_state(2);
        pll_lock = 1'b1;
        repeat (30) @(negedge clkin1);
        pll_lock = 1'b0;
        repeat (2) @(negedge clkin1);
        pll_lock = 1'b1;
        wait_state(4);

        // Late lock: RUN reached one edge before the timeout.
        push(0, 6, 0, 1, 0);
        push(1, 3, 0, 1, 0);
        push(2, 3, 0, 1, 0);
        push(3, 135, 0, 1, 0);
        push(4, 64, 0, 1, 0);
        restart_drop();
        wait_state(2);
        repeat (131) @(negedge clkin1);
        pll_lock = 1'b1;
        wait_state(4);

        // One cycle later: timeout coincides with stable count and wins; retry relocks.
        push(0, 6, 0, 1, 0);
        push(1, 3, 0, 1, 0);
        push(2, 3, 0, 1, 0);
        push(3, 136, 0, 1, 0);
        push(0, 64, 1, 1, 0);
        push(1, 3, 1, 1, 0);
        push(2, 3, 1, 1, 0);
        push(3, 1, 1, 1, 0);
        push(4, 64, 1, 1, 0);
        restart_drop();
        wait_state(2);
        repeat (132) @(negedge clkin1);
        pll_lock = 1'b1;
        wait_state(0);
        wait_state(4);

        // No lock: four attempts then FAIL.
        push(0, 6, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            push(1, 3, 2'(i), 1, 0);
            push(2, 3, 2'(i), 1, 0);
            if (i < 3) push(0, 200, 2'(i + 1), 1, 0);
            else       push(5, 200, 3, 1, 0);
        end
        restart_drop();
        wait_state(5);
        pll_lock = 1'b1;
        repeat (20) @(negedge clkin1);

        // Restart out of FAIL; lock ignored while failed.
        push(0, 21, 0, 1, 0);
        push(1, 3, 0, 1, 0);
        push(2, 3, 0, 1, 0);
        push(3, 4, 0, 1, 0);
        restart_req = 1'b1;
        pll_lock    = 1'b0;
        @(negedge clkin1);
        restart_req = 1'b0;
        wait_state(2);
        pll_lock = 1'b1;
        wait_state(3);

        // Asynchronous reset between edges while in STABLE_CHK.
        repeat (10) @(negedge clkin1);
        #3 rst = 1'b1;
        #2 check_reset_vals();
        push(1, 3, 0, 0, 0);
        push(2, 3, 0, 0, 0);
        push(3, 1, 0, 0, 0);
        push(4, 64, 0, 0, 0);
        @(negedge clkin1);
        #5 rst = 1'b0;
        wait_state(4);
        repeat (5) @(negedge clkin1);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Power-up, reset and lock-supervision controller for the clk_pll_top PLL wrapper.
- Runs on the PLL reference clock. Drives the PLL power-down and reset pins and filters the asynchronous lock output.
- Holds a downstream user reset until lock has been stable. Retries on lock timeout, restarts on lock loss, and reports status.

Parameters:
- PWD_CYCLES, 3: clkin1 cycles pll_pwd is held high per attempt (>=1).
- RST_CYCLES, 3: clkin1 cycles pll_rst is held high after pll_pwd falls (>=1).
- LOCK_TIMEOUT_CYCLES, 50000: cycles allowed from pll_rst release to reaching RUN (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 64: consecutive synchronized-lock-high cycles required before RUN (>=1).
- MAX_RETRIES, 3: extra attempts after the first timeout before FAIL.
- SYNC_STAGES, 3: lock synchronizer depth (>=2).

Ports:
- clkin1  in  1  reference clock; all logic in this domain.
- rst  in  1  asynchronous, active-high reset.
- pll_lock  in  1  PLL lock, asynchronous to clkin1.
- restart_req  in  1  single-cycle request to re-run the full sequence.
- pll_pwd  out  1  to PLL power-down pin.
- pll_rst  out  1  to PLL reset pin.
- user_rst  out  1  active-high reset for logic clocked by clkout0..3.
- clk_ready  out  1  PLL locked and stable.
- lock_lost  out  1  one-cycle pulse on lock drop while in RUN.
- fail  out  1  retries exhausted; sticky.
- retry_cnt  out  $clog2(MAX_RETRIES+1)  timeouts in the current sequence.
- lock_loss_cnt  out  8  saturating count of lock_lost events.
- state  out  3  current state code, for debug.

Behaviour:
- Clock and reset: one clock, clkin1. Reset rst is asynchronous, active-high.
- Reset values:
  - state=PWD.
  - pll_pwd=1, pll_rst=1, user_rst=1.
  - clk_ready=0, lock_lost=0, fail=0.
  - retry_cnt=0, lock_loss_cnt=0.
  - Synchronizer flops=0.
- Lock synchronization: pll_lock passes through SYNC_STAGES flops; the output is lock_s. Only lock_s is used internally.
- Outputs: all are flops loaded from the next-state decode, so each changes on the same edge as state. No combinational glitches reach the PLL pins.
- Output decode per state:
  - pll_pwd=1 in PWD and FAIL.
  - pll_rst=1 in PWD, RST and FAIL.
  - user_rst=0 only in RUN.
  - clk_ready=1 only in RUN.
  - fail=1 only in FAIL.
- State codes: PWD=0, RST=1, WAIT_LOCK=2, STABLE_CHK=3, RUN=4, FAIL=5.
- Counters:
  - phase_cnt: cleared on entry to every state.
  - tmo_cnt: cleared on RST->WAIT_LOCK; counts in WAIT_LOCK and STABLE_CHK.
  - stab_cnt: cleared on entry to STABLE_CHK.
- PWD: stay exactly PWD_CYCLES cycles, then go to RST.
- RST: stay exactly RST_CYCLES cycles, then go to WAIT_LOCK.
- WAIT_LOCK:
  - lock_s=1 -> STABLE_CHK.
  - Otherwise, when tmo_cnt reaches LOCK_TIMEOUT_CYCLES-1: if retry_cnt==MAX_RETRIES -> FAIL; else retry_cnt+1 and go to PWD.
- STABLE_CHK:
  - lock_s=0 -> WAIT_LOCK; tmo_cnt keeps running.
  - Timeout is checked as in WAIT_LOCK and has priority over reaching the stable count.
  - After LOCK_STABLE_CYCLES consecutive cycles of lock_s=1 -> RUN.
- RUN: lock_s=0 -> PWD, with all of the following on that same edge:
  - lock_lost pulses 1 cycle.
  - lock_loss_cnt increments, saturating at 255.
  - retry_cnt clears.
  - user_rst rises and clk_ready falls.
- FAIL: hold until restart_req or rst. pll_lock is ignored.
- restart_req: from any state -> PWD next edge. Clears retry_cnt, fail and all counters. Has highest priority over every other transition. Never pulses lock_lost, even in RUN. lock_loss_cnt is preserved.
- Lock latency:
  - Let edge k be the first edge sampling pll_lock=1 while in WAIT_LOCK, with lock then steady.
  - state=STABLE_CHK after edge k+SYNC_STAGES.
  - clk_ready=1 and user_rst=0 after edge k+SYNC_STAGES+LOCK_STABLE_CYCLES.
- Lock glitch: a pll_lock glitch shorter than one cycle may or may not be captured. Either outcome is legal; no metastable value propagates.
- rst mid-sequence: returns everything to the reset values immediately, asynchronously.

Decomposition:
- Package pll_seq_pkg holds:
  - State code constants.
  - A counter-width function, clog2 of max+1.
  - Default timing constants.
- One sub-module, pll_lock_sync: a SYNC_STAGES-deep flop chain with asynchronous reset to 0.
- FSM and counters stay in pll_lock_sequencer.

Test Plan:
1. Nominal lock: rst high 100 ns then low; pll_lock rises 2 us later and stays high.
   - pll_pwd high for exactly 3 cycles, then pll_rst high for exactly 3 cycles.
   - clk_ready rises 3+64 cycles after lock is first sampled; user_rst falls on the same edge; retry_cnt=0.
2. Timeout with retries: LOCK_TIMEOUT_CYCLES=200, pll_lock held 0.
   - Four full PWD/RST/WAIT sequences; retry_cnt counts 1, 2, 3.
   - Then fail=1 and state=5; pll_pwd=1 and pll_rst=1 are held.
3. Flapping lock: lock high 30 cycles, low 2, then high.
   - Returns to WAIT_LOCK and re-enters STABLE_CHK; clk_ready waits a full 64 stable cycles.
   - With LOCK_TIMEOUT_CYCLES=80, a timeout fires instead.
4. Lock loss in RUN: drop pll_lock for 10 cycles.
   - Exactly one lock_lost pulse; lock_loss_cnt=1; user_rst=1 and clk_ready=0 on the same edge.
   - Full re-sequence follows, and relock returns clk_ready=1.
5. Restart: restart_req in FAIL -> fail clears and PWD is entered next edge; pulse restart_req in RUN -> no lock_lost pulse, lock_loss_cnt unchanged.
6. Async reset: assert rst mid-STABLE_CHK between clock edges.
   - All outputs take reset values before the next edge.
